// File: rtl/johnson_seq_ctrl.sv
// johnson_seq_ctrl
//   Run/stop/step sequencer around a WIDTH-bit Johnson counter. Runs a
//   programmed number of full rotations (2*WIDTH states each) in either
//   direction and decodes the counter into a one-hot phase-enable bus.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   reset      synchronous, active-high reset
//   start      begin a run from IDLE (latches cycles and dir)
//   stop       abort a run; counter holds its value
//   step       single advance in dir while IDLE
//   dir        0 = forward, 1 = reverse
//   cycles     rotations to run, 0 = continuous until stop
//   load       write load_val into the counter while IDLE
//   load_val   start phase code
//   pause      (JOHNSON_SEQ_PAUSE_EN only) freeze a run in place
//   count      Johnson counter value
//   phase      one-hot decode of count
//   busy       high while running
//   done       one-cycle pulse after the programmed rotations complete
//   err        sticky illegal-load flag, cleared by start
//
// Build option
//   JOHNSON_SEQ_PAUSE_EN  adds the pause input
//
// FSM states
//   state   | meaning
//   IDLE    | waiting; start / load / step accepted (in that priority)
//   RUN     | advancing every edge in the latched direction
//   DONE    | one-cycle done pulse, back to IDLE
module johnson_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CYC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               step,
  input  logic               dir,
  input  logic [CYC_W-1:0]   cycles,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
`ifdef JOHNSON_SEQ_PAUSE_EN
  input  logic               pause,
`endif
  output logic [WIDTH-1:0]   count,
  output logic [2*WIDTH-1:0] phase,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state;
  logic [CYC_W-1:0] rot_cnt;
  logic [CYC_W-1:0] cyc_lat;
  logic             dir_lat;
  logic             run_hold;
  logic [WIDTH-1:0] run_next;
  logic             wrap;
  logic [CYC_W-1:0] rot_inc;
  logic             load_legal;
  int               load_edges;
  int               ones;
  int               phase_k;

`ifdef JOHNSON_SEQ_PAUSE_EN
  assign run_hold = pause;
`else
  assign run_hold = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] c,
                                               input logic rev);
    if (rev) return {c[WIDTH-2:0], ~c[WIDTH-1]};
    else     return {~c[0], c[WIDTH-1:1]};
  endfunction

  assign run_next = advance(count, dir_lat);
  assign wrap     = (run_next == '0);
  // rotation counter saturates at all-ones rather than rolling over
  assign rot_inc  = (&rot_cnt) ? rot_cnt : rot_cnt + CYC_W'(1);

  // A Johnson code has at most one 0/1 boundary between adjacent bits.
  always_comb begin
    load_edges = 0;
    for (int i = 0; i < WIDTH-1; i++) begin
      if (load_val[i] != load_val[i+1]) load_edges++;
    end
  end
  assign load_legal = (load_edges <= 1);

  // Phase index: ones fill from the MSB during the first half (k = ones),
  // then drain from the MSB during the second half (k = 2*WIDTH - ones).
  always_comb begin
    ones = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (count[i]) ones++;
    end
    if (count[WIDTH-1])  phase_k = ones;
    else if (ones == 0)  phase_k = 0;
    else                 phase_k = 2*WIDTH - ones;
    for (int i = 0; i < 2*WIDTH; i++) begin
      phase[i] = (phase_k == i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      count   <= '0;
      rot_cnt <= '0;
      cyc_lat <= '0;
      dir_lat <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= ST_RUN;
            busy    <= 1'b1;
            cyc_lat <= cycles;
            dir_lat <= dir;
            rot_cnt <= '0;
            err     <= 1'b0;
          end else if (load) begin
            if (load_legal) begin
              count <= load_val;
            end else begin
              count <= '0;
              err   <= 1'b1;
            end
          end else if (step) begin
            count <= advance(count, dir);
          end
        end

        ST_RUN: begin
          // stop wins over both the advance and a pending completion
          if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (!run_hold) begin
            count <= run_next;
            if (wrap) begin
              rot_cnt <= rot_inc;
              if ((cyc_lat != '0) && (rot_inc == cyc_lat)) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Testbench for johnson_seq_ctrl (WIDTH=4, CYC_W=8). Directed scenarios plus
// a randomized run compared against a phase-index reference model.
module tb_johnson_seq_ctrl;

  localparam int W  = 4;
  localparam int CW = 8;
  localparam int PW = 2*W;

  logic          clk;
  logic          reset;
  logic          start;
  logic          stop;
  logic          step;
  logic          dir;
  logic [CW-1:0] cycles;
  logic          load;
  logic [W-1:0]  load_val;
`ifdef JOHNSON_SEQ_PAUSE_EN
  logic          pause;
`endif
  logic [W-1:0]  count;
  logic [PW-1:0] phase;
  logic          busy;
  logic          done;
  logic          err;

  int n_chk;
  int n_fail;

  // reference model: phase index, mode (0 idle, 1 run, 2 done), rotations
  int m_k;
  int m_st;
  int m_rot;
  int m_cyc;
  int m_dir;
  int m_err;

  johnson_seq_ctrl #(.WIDTH(W), .CYC_W(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .step     (step),
    .dir      (dir),
    .cycles   (cycles),
    .load     (load),
    .load_val (load_val),
`ifdef JOHNSON_SEQ_PAUSE_EN
    .pause    (pause),
`endif
    .count    (count),
    .phase    (phase),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // code at forward position k: k ones from the MSB, then draining from the MSB
  function automatic logic [W-1:0] code_of(input int k);
    if (k <= W) code_of = W'(((1 << k) - 1) << (W - k));
    else        code_of = W'((1 << (2*W - k)) - 1);
  endfunction

  function automatic int paused_now();
`ifdef JOHNSON_SEQ_PAUSE_EN
    return (pause === 1'b1) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic model_update();
    int found;
    if (reset) begin
      m_k = 0; m_st = 0; m_rot = 0; m_err = 0;
      return;
    end
    case (m_st)
      0: begin
        if (start) begin
          m_st = 1; m_cyc = int'(cycles); m_dir = int'(dir); m_rot = 0; m_err = 0;
        end else if (load) begin
          found = -1;
          for (int k = 0; k < PW; k++) if (code_of(k) == load_val) found = k;
          if (found >= 0) m_k = found;
          else begin m_k = 0; m_err = 1; end
        end else if (step) begin
          m_k = dir ? (m_k + PW - 1) % PW : (m_k + 1) % PW;
        end
      end
      1: begin
        if (stop) m_st = 0;
        else if (paused_now() == 0) begin
          m_k = (m_dir != 0) ? (m_k + PW - 1) % PW : (m_k + 1) % PW;
          if (m_k == 0) begin
            if (m_rot < (1 << CW) - 1) m_rot++;
            if (m_cyc != 0 && m_rot == m_cyc) m_st = 2;
          end
        end
      end
      default: m_st = 0;
    endcase
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; step = 0; load = 0; reset = 0;
`ifdef JOHNSON_SEQ_PAUSE_EN
    pause = 0;
`endif
  endtask

  task automatic test_reset();
    reset = 1; tick(); tick(); reset = 0;
    n_chk++; if (count !== 4'h0) begin n_fail++; $display("FAIL reset_count got %h exp 0", count); end
    n_chk++; if (phase !== 8'h01) begin n_fail++; $display("FAIL reset_phase got %h exp 01", phase); end
    n_chk++; if ({busy, done, err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got busy=%b done=%b err=%b exp 000", busy, done, err); end
  endtask

  task automatic test_forward_run();
    logic [W-1:0] fwd [8];
    fwd = '{4'h8, 4'hC, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1, 4'h0};
    cycles = 8'd2; dir = 0; start = 1; tick(); start = 0;
    n_chk++; if (busy !== 1'b1 || count !== 4'h0) begin n_fail++; $display("FAIL fwd_start got busy=%b count=%h exp 1 0", busy, count); end
    for (int i = 0; i < 15; i++) begin
      cycles = 8'd7; dir = 1;  // must be ignored while running
      tick();
      n_chk++; if (count !== fwd[i % 8] || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++; $display("FAIL fwd_seq i=%0d got count=%h busy=%b done=%b exp %h 1 0", i, count, busy, done, fwd[i % 8]);
      end
    end
    tick();
    n_chk++; if (done !== 1'b1 || busy !== 1'b0 || count !== 4'h0 || phase !== 8'h01) begin
      n_fail++; $display("FAIL fwd_done got done=%b busy=%b count=%h phase=%h exp 1 0 0 01", done, busy, count, phase);
    end
    tick();
    n_chk++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL fwd_after got done=%b busy=%b exp 0 0", done, busy); end
  endtask

  task automatic test_reverse_stop();
    logic [W-1:0] rev [4];
    rev = '{4'h1, 4'h3, 4'h7, 4'hF};
    cycles = 8'd0; dir = 1; start = 1; tick(); start = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if (count !== rev[i]) begin n_fail++; $display("FAIL rev_seq i=%0d got %h exp %h", i, count, rev[i]); end
    end
    stop = 1; tick(); stop = 0;
    n_chk++; if (count !== 4'hF || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rev_stop got count=%h busy=%b done=%b exp F 0 0", count, busy, done);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if (count !== 4'hF || done !== 1'b0) begin n_fail++; $display("FAIL rev_hold i=%0d got count=%h done=%b exp F 0", i, count, done); end
    end
  endtask

  task automatic test_step();
    int adv;
    load_val = 4'h0; load = 1; tick(); load = 0;
    step = 1; dir = 0; tick();
    n_chk++; if (count !== 4'h8 || busy !== 1'b0) begin n_fail++; $display("FAIL step_fwd got count=%h busy=%b exp 8 0", count, busy); end
    dir = 1; tick(); step = 0;
    n_chk++; if (count !== 4'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL step_rev got count=%h busy=%b exp 0 0", count, busy); end
    cycles = 8'd1; dir = 0; start = 1; tick(); start = 0;
    adv = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) break;
      tick(); adv++;
    end
    n_chk++; if (adv !== 8 || done !== 1'b1) begin n_fail++; $display("FAIL step_then_run got advances=%0d done=%b exp 8 1", adv, done); end
    tick();
  endtask

  task automatic test_load_err();
    load_val = 4'b1010; load = 1; tick();
    n_chk++; if (count !== 4'h0 || err !== 1'b1) begin n_fail++; $display("FAIL load_bad got count=%h err=%b exp 0 1", count, err); end
    load_val = 4'b0111; tick(); load = 0;
    n_chk++; if (count !== 4'h7 || phase !== 8'h20 || err !== 1'b1) begin
      n_fail++; $display("FAIL load_good got count=%h phase=%h err=%b exp 7 20 1", count, phase, err);
    end
    cycles = 8'd0; dir = 0; start = 1; load = 1; load_val = 4'b1010; tick(); start = 0; load = 0;
    n_chk++; if (err !== 1'b0 || count !== 4'h7 || busy !== 1'b1) begin
      n_fail++; $display("FAIL load_start got err=%b count=%h busy=%b exp 0 7 1", err, count, busy);
    end
    load = 1; tick(); load = 0;  // ignored in RUN
    n_chk++; if (count !== 4'h3 || err !== 1'b0) begin n_fail++; $display("FAIL load_in_run got count=%h err=%b exp 3 0", count, err); end
    stop = 1; tick(); stop = 0;
  endtask

  task automatic test_reset_midrun();
    int saw_done;
    load_val = 4'h0; load = 1; tick(); load = 0;
    cycles = 8'd3; dir = 0; start = 1; tick(); start = 0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1; tick(); reset = 0;
    n_chk++; if (count !== 4'h0 || busy !== 1'b0 || done !== 1'b0 || phase !== 8'h01) begin
      n_fail++; $display("FAIL rst_mid got count=%h busy=%b done=%b phase=%h exp 0 0 0 01", count, busy, done, phase);
    end
    saw_done = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) saw_done++;
    end
    n_chk++; if (saw_done !== 0) begin n_fail++; $display("FAIL rst_mid_quiet got %0d active cycles exp 0", saw_done); end
  endtask

`ifdef JOHNSON_SEQ_PAUSE_EN
  task automatic test_pause();
    int busy_n;
    cycles = 8'd1; dir = 0; start = 1; tick(); start = 0;
    busy_n = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy !== 1'b1) break;
      busy_n++;
      pause = (i >= 3 && i < 6);
      tick();
    end
    pause = 0;
    n_chk++; if (busy_n !== 11 || done !== 1'b1) begin n_fail++; $display("FAIL pause_stretch got busy=%0d done=%b exp 11 1", busy_n, done); end
    tick();
  endtask
`endif

  task automatic test_random();
    logic [PW-1:0] exp_phase;
    reset = 1; tick(); reset = 0;
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      start    = ($urandom_range(0, 7) == 0);
      stop     = ($urandom_range(0, 23) == 0);
      step     = ($urandom_range(0, 2) == 0);
      load     = ($urandom_range(0, 5) == 0);
      dir      = 1'($urandom_range(0, 1));
      cycles   = 8'($urandom_range(0, 3));
      load_val = 4'($urandom_range(0, 15));
`ifdef JOHNSON_SEQ_PAUSE_EN
      pause    = ($urandom_range(0, 4) == 0);
`endif
      tick();
      exp_phase = '0; exp_phase[m_k] = 1'b1;
      n_chk++; if (count !== code_of(m_k)) begin n_fail++; $display("FAIL rnd_count i=%0d got %h exp %h", i, count, code_of(m_k)); end
      n_chk++; if (phase !== exp_phase) begin n_fail++; $display("FAIL rnd_phase i=%0d got %h exp %h", i, phase, exp_phase); end
      n_chk++; if (busy !== (m_st == 1)) begin n_fail++; $display("FAIL rnd_busy i=%0d got %b exp %0d", i, busy, m_st == 1); end
      n_chk++; if (done !== (m_st == 2)) begin n_fail++; $display("FAIL rnd_done i=%0d got %b exp %0d", i, done, m_st == 2); end
      n_chk++; if (err !== m_err[0]) begin n_fail++; $display("FAIL rnd_err i=%0d got %b exp %0d", i, err, m_err); end
    end
    idle_inputs();
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    m_k = 0; m_st = 0; m_rot = 0; m_cyc = 0; m_dir = 0; m_err = 0;
    idle_inputs();
    dir = 0; cycles = '0; load_val = '0;
    test_reset();
    test_forward_run();
    test_reverse_stop();
    test_step();
    test_load_err();
    test_reset_midrun();
`ifdef JOHNSON_SEQ_PAUSE_EN
    test_pause();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
